// File: rtl/render_pkg.sv
// Shared types and constants for the pixel renderer.
package render_pkg;

  localparam int unsigned ROW_W = 9;
  localparam int unsigned COL_W = 10;
  localparam int unsigned CMP_W = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COLOR_BLACK  = 24'h000000;
  localparam rgb_t COLOR_SKY    = 24'h70C5CE;
  localparam rgb_t COLOR_PIPE   = 24'h2E8B22;
  localparam rgb_t COLOR_BIRD   = 24'hFFD700;
  localparam rgb_t COLOR_GROUND = 24'hDED895;

  localparam logic [ROW_W-1:0] RST_BIRD_Y = 9'd240;
  localparam logic [COL_W-1:0] RST_PIPE_X = 10'd640;
  localparam logic [ROW_W-1:0] RST_GAP_Y  = 9'd200;
  localparam logic [ROW_W-1:0] GROUND_ROW = 9'd448;

  typedef struct packed {
    logic [ROW_W-1:0] bird_y;
    logic [COL_W-1:0] pipe_x;
    logic [ROW_W-1:0] gap_y;
  } pos_t;

  localparam pos_t RST_POS = '{bird_y: RST_BIRD_Y, pipe_x: RST_PIPE_X, gap_y: RST_GAP_Y};

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } upd_state_t;

  // Inclusive range test on zero-extended coordinates.
  function automatic logic in_span(input logic [CMP_W-1:0] v,
                                   input logic [CMP_W-1:0] lo,
                                   input logic [CMP_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage, W-bit shift register with synchronous active-low clear.
module sync_delay #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [N];

  // Shift d through N registers; clear empties every stage.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[N-1];

endmodule

// File: rtl/pixel_render.sv
// Two-stage pixel renderer for a bird / pipe / ground scene.
// Positions are double-buffered and swap only at the VS falling edge.
// Build option: define GROUND_EN to paint rows 448..479 as ground.
module pixel_render
  import render_pkg::*;
#(
  parameter int unsigned BIRD_COL = 100,
  parameter int unsigned PIPE_W   = 48,
  parameter int unsigned GAP_H    = 120
) (
  input  logic             CLOCK_50,
  input  logic             reset_L,
  input  logic             HS,
  input  logic             VS,
  input  logic             blank,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [ROW_W-1:0] bird_y,
  input  logic [COL_W-1:0] pipe_x,
  input  logic [ROW_W-1:0] gap_y,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             frame_done
);

  upd_state_t state_q, state_d;
  pos_t       active_q, active_d;
  pos_t       shadow_q, shadow_d;
  logic       vs_q;
  logic       boundary_c;

  // Registered VS; cleared so no boundary is seen until VS is sampled.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_L) vs_q <= 1'b0;
    else          vs_q <= VS;
  end

  assign boundary_c = vs_q & ~VS;
  assign frame_done = boundary_c;

  // Update FSM state plus shadow/active position registers.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      active_q <= RST_POS;
      shadow_q <= RST_POS;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

  // Capture offered positions when idle; commit them at the next boundary.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    upd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          shadow_d = '{bird_y: bird_y, pipe_x: pipe_x, gap_y: gap_y};
          state_d  = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (boundary_c) begin
          active_d = shadow_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [COL_W-1:0] bird_bot_c;
  logic [CMP_W-1:0] pipe_r_c;
  logic [COL_W-1:0] gap_bot_c;
  logic             bird_hit_c, pipe_hit_c, ground_hit_c;

  assign bird_bot_c = {1'b0, active_q.bird_y} + 10'd15;
  assign pipe_r_c   = {1'b0, active_q.pipe_x} + CMP_W'(PIPE_W - 1);
  assign gap_bot_c  = {1'b0, active_q.gap_y} + COL_W'(GAP_H - 1);

  assign bird_hit_c = in_span(CMP_W'(col), CMP_W'(BIRD_COL), CMP_W'(BIRD_COL + 15)) &&
                      in_span(CMP_W'(row), CMP_W'(active_q.bird_y), CMP_W'(bird_bot_c));

  assign pipe_hit_c = in_span(CMP_W'(col), CMP_W'(active_q.pipe_x), pipe_r_c) &&
                      !in_span(CMP_W'(row), CMP_W'(active_q.gap_y), CMP_W'(gap_bot_c));

`ifdef GROUND_EN
  assign ground_hit_c = (row >= GROUND_ROW);
`else
  assign ground_hit_c = 1'b0;
`endif

  logic bird_s1, pipe_s1, ground_s1, blank_s1;

  // Stage 1: hit flags, suppressed during blanking.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_L) begin
      bird_s1   <= 1'b0;
      pipe_s1   <= 1'b0;
      ground_s1 <= 1'b0;
      blank_s1  <= 1'b1;
    end else begin
      bird_s1   <= bird_hit_c & ~blank;
      pipe_s1   <= pipe_hit_c & ~blank;
      ground_s1 <= ground_hit_c & ~blank;
      blank_s1  <= blank;
    end
  end

  rgb_t color_c, color_q;

  // Colour priority: bird over pipe over ground over sky; black when blanked.
  always_comb begin
    color_c = COLOR_SKY;
    if (blank_s1)       color_c = COLOR_BLACK;
    else if (bird_s1)   color_c = COLOR_BIRD;
    else if (pipe_s1)   color_c = COLOR_PIPE;
    else if (ground_s1) color_c = COLOR_GROUND;
  end

  // Stage 2: registered colour.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_L) color_q <= COLOR_BLACK;
    else          color_q <= color_c;
  end

  assign VGA_R = color_q.r;
  assign VGA_G = color_q.g;
  assign VGA_B = color_q.b;

  // Timing is stored inverted so a cleared delay line reads HS=VS=1, BLANK_N=0.
  logic [2:0] sync_q;

  sync_delay #(
    .N(2),
    .W(3)
  ) u_sync_delay (
    .clk   (CLOCK_50),
    .clr_n (reset_L),
    .d     ({~HS, ~VS, ~blank}),
    .q     (sync_q)
  );

  assign VGA_HS      = ~sync_q[2];
  assign VGA_VS      = ~sync_q[1];
  assign VGA_BLANK_N = sync_q[0];

endmodule

// File: tb/tb_pixel_render.sv
// Randomised bench for pixel_render against a frame-level reference model.
module tb_pixel_render;

  localparam int BIRD_COL = 100;
  localparam int PIPE_W   = 48;
  localparam int GAP_H    = 120;
`ifdef GROUND_EN
  localparam bit GROUND_ON = 1'b1;
`else
  localparam bit GROUND_ON = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset_L;
  logic       HS, VS, blank;
  logic [8:0] row;
  logic [9:0] col;
  logic       upd_valid, upd_ready;
  logic [8:0] bird_y;
  logic [9:0] pipe_x;
  logic [8:0] gap_y;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, frame_done;

  always #10 CLOCK_50 = ~CLOCK_50;

  pixel_render #(
    .BIRD_COL(BIRD_COL),
    .PIPE_W  (PIPE_W),
    .GAP_H   (GAP_H)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_L     (reset_L),
    .HS          (HS),
    .VS          (VS),
    .blank       (blank),
    .row         (row),
    .col         (col),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .bird_y      (bird_y),
    .pipe_x      (pipe_x),
    .gap_y       (gap_y),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .frame_done  (frame_done)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: active/shadow positions, pending flag, previous VS.
  int m_by, m_px, m_gy, s_by, s_px, s_gy;
  bit m_pend, m_vs_prev;
  logic [26:0] exp_hist [2];   // {rgb, hs, vs, blank_n} for 1 and 2 cycles ago

  function automatic logic [23:0] ref_color(int r, int c, int by, int px, int gy);
    bit bird, pipe, ground;
    bird   = (c >= BIRD_COL) && (c <= BIRD_COL + 15) && (r >= by) && (r <= by + 15);
    pipe   = (c >= px) && (c <= px + PIPE_W - 1) && !((r >= gy) && (r <= gy + GAP_H - 1));
    ground = GROUND_ON && (r >= 448);
    if (bird)   return 24'hFFD700;
    if (pipe)   return 24'h2E8B22;
    if (ground) return 24'hDED895;
    return 24'h70C5CE;
  endfunction

  task automatic model_reset();
    m_by = 240; m_px = 640; m_gy = 200;
    s_by = 240; s_px = 640; s_gy = 200;
    m_pend = 1'b0;
    m_vs_prev = 1'b0;
    exp_hist[0] = {24'h0, 1'b1, 1'b1, 1'b0};
    exp_hist[1] = {24'h0, 1'b1, 1'b1, 1'b0};
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    upd_valid = 1'b0;
    blank = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset_L = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive, check at negedge, advance the model at posedge.
  task automatic step(input bit hs, input bit vs, input bit bl, input int r, input int c,
                      input bit uv, input int by, input int px, input int gy,
                      output logic [23:0] s_rgb, output logic [2:0] s_tm,
                      output logic s_fd, output logic s_rdy);
    bit bnd;
    logic [26:0] exp_now;
    HS = hs; VS = vs; blank = bl;
    row = 9'(r); col = 10'(c);
    upd_valid = uv;
    bird_y = 9'(by); pipe_x = 10'(px); gap_y = 9'(gy);
    @(negedge CLOCK_50);
    s_rgb = {VGA_R, VGA_G, VGA_B};
    s_tm  = {VGA_HS, VGA_VS, VGA_BLANK_N};
    s_fd  = frame_done;
    s_rdy = upd_ready;
    chk("rgb", s_rgb, exp_hist[1][26:3]);
    chk("timing", s_tm, exp_hist[1][2:0]);
    bnd = m_vs_prev && !vs;
    chk("frame_done", s_fd, bnd);
    chk("upd_ready", s_rdy, !m_pend);
    exp_now = {(bl ? 24'h0 : ref_color(r, c, m_by, m_px, m_gy)), hs, vs, !bl};
    exp_hist[1] = exp_hist[0];
    exp_hist[0] = exp_now;
    @(posedge CLOCK_50);
    if (!m_pend) begin
      if (uv) begin
        s_by = by; s_px = px; s_gy = gy;
        m_pend = 1'b1;
      end
    end else if (bnd) begin
      m_by = s_by; m_px = s_px; m_gy = s_gy;
      m_pend = 1'b0;
    end
    m_vs_prev = vs;
    #1;
  endtask

  logic [23:0] o_rgb;
  logic [2:0]  o_tm;
  logic        o_fd, o_rdy;

  task automatic idle();
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, o_rgb, o_tm, o_fd, o_rdy);
  endtask

  // Offer positions, then run a VS falling edge so they become active.
  task automatic commit(input int by, input int px, input int gy);
    step(1, 1, 1, 0, 0, 1, by, px, gy, o_rgb, o_tm, o_fd, o_rdy);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, o_rgb, o_tm, o_fd, o_rdy);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, o_rgb, o_tm, o_fd, o_rdy);
  endtask

  // Drive one pixel, return the colour seen two cycles later.
  task automatic pix(input int r, input int c, input bit bl, output logic [23:0] res);
    step(1, 1, bl, r, c, 0, 0, 0, 0, o_rgb, o_tm, o_fd, o_rdy);
    idle();
    idle();
    res = o_rgb;
  endtask

  logic [23:0] px_rgb;

  initial begin
    HS = 1'b1; VS = 1'b1; blank = 1'b1; row = '0; col = '0;
    upd_valid = 1'b0; bird_y = '0; pipe_x = '0; gap_y = '0;
    do_reset();

    // Reset values hold through idle cycles.
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_rgb", o_rgb, 24'h0);
      chk("rst_tim", o_tm, 3'b110);
      chk("rst_rdy", o_rdy, 1'b1);
    end

    // Bird hit and its edges.
    commit(100, 640, 200);
    pix(105, 107, 0, px_rgb); chk("bird_hit", px_rgb, 24'hFFD700);
    pix(115, 115, 0, px_rgb); chk("bird_corner", px_rgb, 24'hFFD700);
    pix(105, 116, 0, px_rgb); chk("bird_right_out", px_rgb, 24'h70C5CE);
    pix(116, 107, 0, px_rgb); chk("bird_below_out", px_rgb, 24'h70C5CE);

    // Pipe body vs gap.
    commit(240, 600, 200);
    pix(100, 630, 0, px_rgb); chk("pipe_hit", px_rgb, 24'h2E8B22);
    pix(250, 630, 0, px_rgb); chk("pipe_gap", px_rgb, 24'h70C5CE);
    commit(240, 500, 200);
    pix(100, 547, 0, px_rgb); chk("pipe_right_edge", px_rgb, 24'h2E8B22);
    pix(100, 548, 0, px_rgb); chk("pipe_right_out", px_rgb, 24'h70C5CE);
    pix(100, 499, 0, px_rgb); chk("pipe_left_out", px_rgb, 24'h70C5CE);
    pix(199, 520, 0, px_rgb); chk("gap_top_out", px_rgb, 24'h2E8B22);
    pix(200, 520, 0, px_rgb); chk("gap_top_in", px_rgb, 24'h70C5CE);
    pix(319, 520, 0, px_rgb); chk("gap_bot_in", px_rgb, 24'h70C5CE);
    pix(320, 520, 0, px_rgb); chk("gap_bot_out", px_rgb, 24'h2E8B22);

    // Ground rows and blanking.
    pix(460, 10, 0, px_rgb);
    chk("ground_row", px_rgb, GROUND_ON ? 24'hDED895 : 24'h70C5CE);
    pix(460, 10, 1, px_rgb); chk("blank_black", px_rgb, 24'h0);

    // Mid-frame update waits for the boundary.
    commit(240, 640, 200);
    step(1, 1, 0, 10, 10, 1, 50, 640, 200, o_rgb, o_tm, o_fd, o_rdy);
    idle(); chk("mid_rdy_low", o_rdy, 1'b0);
    pix(245, 105, 0, px_rgb); chk("mid_old_bird", px_rgb, 24'hFFD700);
    pix(55, 105, 0, px_rgb);  chk("mid_new_absent", px_rgb, 24'h70C5CE);
    idle();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, o_rgb, o_tm, o_fd, o_rdy);
    chk("mid_frame_done", o_fd, 1'b1);
    idle(); chk("mid_fd_pulse", o_fd, 1'b0); chk("mid_rdy_back", o_rdy, 1'b1);
    pix(55, 105, 0, px_rgb); chk("mid_new_bird", px_rgb, 24'hFFD700);

    // Update coincident with a boundary applies one frame later.
    idle();
    step(1, 0, 1, 0, 0, 1, 30, 640, 200, o_rgb, o_tm, o_fd, o_rdy);
    chk("coin_frame_done", o_fd, 1'b1);
    idle(); chk("coin_rdy_low", o_rdy, 1'b0);
    pix(35, 105, 0, px_rgb); chk("coin_not_yet", px_rgb, 24'h70C5CE);
    idle();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, o_rgb, o_tm, o_fd, o_rdy);
    pix(35, 105, 0, px_rgb); chk("coin_applied", px_rgb, 24'hFFD700);

    // Reset while pending discards the shadow; no boundary right after reset.
    step(1, 1, 1, 0, 0, 1, 20, 640, 200, o_rgb, o_tm, o_fd, o_rdy);
    idle(); chk("rp_rdy_low", o_rdy, 1'b0);
    do_reset();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, o_rgb, o_tm, o_fd, o_rdy);
    chk("rp_no_early_fd", o_fd, 1'b0);
    idle();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, o_rgb, o_tm, o_fd, o_rdy);
    chk("rp_fd", o_fd, 1'b1);
    pix(245, 105, 0, px_rgb); chk("rp_bird_reset", px_rgb, 24'hFFD700);
    pix(25, 105, 0, px_rgb);  chk("rp_shadow_gone", px_rgb, 24'h70C5CE);

    // Randomised frames with random updates.
    for (int k = 0; k < 1500; k++) begin
      int fc, r, c, by, px, gy;
      bit vs, bl, hs, uv;
      fc = k % 50;
      vs = (fc >= 3);
      bl = (fc < 8) || ($urandom_range(0, 15) == 0);
      hs = (k % 10) != 0;
      r = int'($urandom_range(0, 479));
      c = int'($urandom_range(0, 639));
      case ($urandom_range(0, 3))
        1: begin
          c = BIRD_COL - 2 + int'($urandom_range(0, 20));
          r = m_by - 2 + int'($urandom_range(0, 20));
        end
        2: begin
          c = m_px - 2 + int'($urandom_range(0, PIPE_W + 4));
          r = m_gy - 2 + int'($urandom_range(0, 4)) + (($urandom_range(0, 1) == 1) ? GAP_H - 1 : 0);
        end
        default: ;
      endcase
      if (r < 0) r = 0;
      if (r > 479) r = 479;
      if (c < 0) c = 0;
      if (c > 639) c = 639;
      uv = ($urandom_range(0, 7) == 0);
      by = int'($urandom_range(0, 511));
      px = ($urandom_range(0, 3) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639));
      gy = int'($urandom_range(0, 511));
      step(hs, vs, bl, r, c, uv, by, px, gy, o_rgb, o_tm, o_fd, o_rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_render.md
PIXEL_RENDER -- requirements
Module: pixel_render

Interface
REQ-001 SHALL have parameter BIRD_COL, default 100, meaning the leftmost column of the 16x16 bird box.
REQ-002 SHALL have parameter PIPE_W, default 48, meaning the pipe width in columns.
REQ-003 SHALL have parameter GAP_H, default 120, meaning the pipe gap height in rows.
REQ-004 SHALL have the following ports:
- CLOCK_50  in  1  sole clock, all state on rising edge.
- reset_L  in  1  synchronous, active-low reset.
- HS, VS, blank  in  1 each  timing from the VGA timing generator; HS/VS low during sync pulse.
- row  in  9  display row 0..479; don't-care while blank=1.
- col  in  10  display col 0..639; don't-care while blank=1.
- upd_valid  in  1  new game-object positions offered.
- upd_ready  out  1  renderer can accept positions.
- bird_y  in  9  top row of bird.
- pipe_x  in  10  left col of pipe.
- gap_y  in  9  top row of pipe gap.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel color.
- VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  delayed timing.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-005 SHALL be a 2-stage pipeline; every output lags its inputs by exactly 2 cycles, and VGA_HS, VGA_VS and VGA_BLANK_N (=~blank) are delayed identically.
REQ-006 Stage 1 SHALL register the hit flags (bird, pipe, ground); all flags are forced to 0 when blank=1.
REQ-007 Stage 2 SHALL register the color with priority bird > pipe > ground > sky; it outputs 0x000000 when the delayed blank=1.
REQ-008 Bird hit SHALL be BIRD_COL<=col<=BIRD_COL+15 and bird_y<=row<=bird_y+15, computed at 10 bits with no wrap.
REQ-009 Pipe hit SHALL be pipe_x<=col<=pipe_x+PIPE_W-1 (11-bit sum), and not (gap_y<=row<=gap_y+GAP_H-1) (10-bit sum).
REQ-010 Geometry beyond 639/479 SHALL simply be clipped; pipe_x>=640 draws no pipe.
REQ-011 Frame boundary SHALL be the cycle where the registered VS equals 1 and the current VS equals 0; frame_done is asserted that cycle.
REQ-012 The update FSM SHALL have two states:
- IDLE: upd_ready=1; upd_valid captures bird_y/pipe_x/gap_y into shadow registers, then go to PENDING.
- PENDING: upd_ready=0; at a frame boundary, copy shadow to active registers, then go to IDLE.
REQ-013 Valid in IDLE coincident with a boundary SHALL capture and go to PENDING; the new values apply at the next boundary, never mid-frame.
REQ-014 Active position registers SHALL change only at frame boundaries, so no frame tears.

Reset
REQ-015 When reset_L=0 at a clock edge, the block SHALL:
- enter IDLE;
- set active and shadow positions to bird_y=240, pipe_x=640, gap_y=200;
- clear all pipeline stages;
- drive VGA_RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0 and frame_done=0.
REQ-016 Reset mid-PENDING SHALL discard the shadow values; the first boundary after reset SHALL NOT be detected until the registered VS has been sampled once.

Configuration
REQ-017 With GROUND_EN defined, rows 448..479 SHALL set the ground flag (color 0xDED895). Without it, the ground flag SHALL be constant 0 and those rows SHALL render sky or pipe.

Structure
REQ-018 render_pkg SHALL hold rgb_t (packed 8/8/8), the color constants (SKY 0x70C5CE, PIPE 0x2E8B22, BIRD 0xFFD700, GROUND 0xDED895), the reset positions, and GROUND_ROW=448.
REQ-019 Timing delay SHALL use one sub-module, sync_delay, a parameterised N-stage, W-bit shift register with synchronous active-low clear; it is instantiated once for {HS,VS,blank}.

Verification
REQ-020 Reset, then 3 idle cycles: outputs equal the REQ-015 values and upd_ready=1.
REQ-021 Active positions bird_y=100, row=105, col=107, blank=0: VGA_RGB=0xFFD700 exactly 2 cycles later.
REQ-022 Active positions pipe_x=600, gap_y=200, row=100, col=630: result is 0x2E8B22. Same stimulus with row=250: result is 0x70C5CE.
REQ-023 upd_valid with bird_y=50 in mid-frame: upd_ready drops and the rendered bird stays at 240 until the VS falling edge; frame_done pulses, then the bird renders at 50 and upd_ready=1.
REQ-024 upd_valid on the same cycle as a VS falling edge: the FSM enters PENDING and the new values appear only after the following boundary.
REQ-025 row=460, col=10 with GROUND_EN: result is 0xDED895; without GROUND_EN: result is 0x70C5CE. blank=1 gives 0x000000 in either build.
